// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps a packed opcode list through a combinational ALU, feeding each result back as the next operand.
module alu_op_sequencer #(
    parameter int WIDTH   = 7,
    parameter int OPW     = 3,
    parameter int MAX_OPS = 8,
    parameter int LENW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [OPW*MAX_OPS-1:0] in_prog,
    input  logic [LENW-1:0]        in_len,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_op,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_flag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [LENW-1:0]        out_flag_count,
    output logic                   out_zero_seen
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d, b_q, b_d;
    logic [OPW*MAX_OPS-1:0] prog_q, prog_d;
    logic [LENW-1:0]        len_q, len_d, step_q, step_d, count_q, count_d;
    logic                   zero_q, zero_d;
    logic [LENW-1:0]        len_clip;
    logic                   run;
    assign len_clip = (in_len > LENW'(MAX_OPS)) ? LENW'(MAX_OPS) : in_len;
    assign run      = state_q == RUN;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        prog_d  = prog_q;
        len_d   = len_q;
        step_d  = step_q;
        count_d = count_q;
        zero_d  = zero_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                acc_d   = in_a;
                b_d     = in_b;
                prog_d  = in_prog;
                len_d   = len_clip;
                step_d  = '0;
                count_d = '0;
                zero_d  = 1'b0;
                state_d = (len_clip != '0) ? RUN : DONE;
            end
        end else if (state_q == RUN) begin
            acc_d   = alu_result;
            count_d = count_q + LENW'(alu_flag);
            zero_d  = zero_q | ~alu_flag;
            step_d  = step_q + 1'b1;
            state_d = (step_q == len_q - 1'b1) ? DONE : RUN;
        end else begin
            state_d = out_ready ? IDLE : DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            prog_q  <= '0;
            len_q   <= '0;
            step_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            prog_q  <= prog_d;
            len_q   <= len_d;
            step_q  <= step_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end
    // ALU inputs are forced to zero whenever no step is in flight
    assign alu_a          = run ? acc_q : '0;
    assign alu_b          = run ? b_q : '0;
    assign alu_op         = run ? prog_q[step_q*OPW +: OPW] : '0;
    assign in_ready       = state_q == IDLE;
    assign out_valid      = state_q == DONE;
    assign out_result     = out_valid ? acc_q : '0;
    assign out_flag_count = out_valid ? count_q : '0;
    assign out_zero_seen  = out_valid & zero_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives commands through the sequencer against a behavioural ALU and scores results from a queue.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_a = '0, in_b = '0;
    logic [23:0] in_prog = '0;
    logic [3:0]  in_len = '0;
    logic [6:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_flag;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_result;
    logic [3:0]  out_flag_count;
    logic        out_zero_seen;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [6:0]  a, b, res;
        logic [23:0] prog;
        int          n;
        logic [3:0]  cnt;
        logic        zs;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [6:0] alu_f(input logic [6:0] x, input logic [2:0] op);
        return (op == 3'd0) ? ~x : (op == 3'd1) ? {x[0], x[6:1]} : 7'd0;
    endfunction

    assign alu_result = alu_f(alu_a, alu_op);
    assign alu_flag   = |alu_result;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_prog(in_prog), .in_len(in_len),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flag_count(out_flag_count), .out_zero_seen(out_zero_seen)
    );

    function automatic exp_t mk(input logic [6:0] a, b, input logic [23:0] prog, input logic [3:0] len);
        exp_t e;
        logic [6:0] v;
        e.a = a; e.b = b; e.prog = prog; e.n = (len > 4'd8) ? 8 : int'(len);
        e.cnt = '0; e.zs = 1'b0; v = a;
        for (int k = 0; k < e.n; k++) begin
            v = alu_f(v, prog[k*3 +: 3]);
            if (v != 7'd0) e.cnt = e.cnt + 4'd1;
            else e.zs = 1'b1;
        end
        e.res = v;
        return e;
    endfunction

    // Leaves the bench at the falling edge just after the accept edge, in_valid dropped.
    task automatic issue(input logic [6:0] a, b, input logic [23:0] prog, input logic [3:0] len);
        int g;
        sb.push_back(mk(a, b, prog, len));
        @(negedge clk);
        in_a = a; in_b = b; in_prog = prog; in_len = len; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        exp_t e;
        int lat;
        logic [6:0] acc;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_scoreboard: queue size 0 required >0", nm);
            return;
        end
        e = sb.pop_front();
        acc = e.a;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tests++;
            if (alu_a !== acc || alu_b !== e.b || alu_op !== e.prog[(lat%8)*3 +: 3]) begin
                fails++;
                $display("FAIL %s_step%0d: alu_a=%h alu_b=%h alu_op=%0d required %h %h %0d",
                         nm, lat, alu_a, alu_b, alu_op, acc, e.b, e.prog[(lat%8)*3 +: 3]);
            end
            acc = alu_f(acc, e.prog[(lat%8)*3 +: 3]);
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== e.n) begin
            fails++;
            $display("FAIL %s_latency: %0d cycles required %0d", nm, lat, e.n);
        end
        tests++;
        if (out_result !== e.res || out_flag_count !== e.cnt || out_zero_seen !== e.zs) begin
            fails++;
            $display("FAIL %s_result: result=%h count=%0d zero=%b required %h %0d %b",
                     nm, out_result, out_flag_count, out_zero_seen, e.res, e.cnt, e.zs);
        end
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 7'd0 || alu_b !== 7'd0 || alu_op !== 3'd0) begin
            fails++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b alu=%h/%h/%0d required 0 1 0/0/0",
                     nm, out_valid, in_ready, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 7'd0 || out_flag_count !== 4'd0 ||
            out_zero_seen !== 1'b0 || alu_a !== 7'd0 || alu_b !== 7'd0 || alu_op !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h count=%0d zero=%b alu=%h/%h/%0d required 1 0 0 0 0 0/0/0",
                     in_ready, out_valid, out_result, out_flag_count, out_zero_seen, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_not_single();
        issue(7'h55, 7'h00, 24'o0, 4'd1);
        wait_done("not1");
        tests++;
        if (out_result !== 7'h2A) begin
            fails++;
            $display("FAIL not1_value: %h required 2a", out_result);
        end
        release_out("not1");
    endtask

    task automatic test_rotate();
        issue(7'h01, 7'h2C, 24'o111, 4'd3);
        wait_done("rot3");
        tests++;
        if (out_result !== 7'h10 || out_flag_count !== 4'd3) begin
            fails++;
            $display("FAIL rot3_value: %h/%0d required 10/3", out_result, out_flag_count);
        end
        release_out("rot3");
    endtask

    task automatic test_zero_flag();
        issue(7'h7F, 7'h11, 24'o0, 4'd2);
        wait_done("zero");
        tests++;
        if (out_result !== 7'h7F || out_flag_count !== 4'd1 || out_zero_seen !== 1'b1) begin
            fails++;
            $display("FAIL zero_value: %h/%0d/%b required 7f/1/1", out_result, out_flag_count, out_zero_seen);
        end
        release_out("zero");
    endtask

    task automatic test_len_edges();
        issue(7'h33, 7'h05, 24'o7777, 4'd0);
        wait_done("len0");
        release_out("len0");
        issue(7'h01, 7'h06, 24'o11111111, 4'd15);
        wait_done("len15");
        tests++;
        if (out_result !== 7'h40 || out_flag_count !== 4'd8) begin
            fails++;
            $display("FAIL len15_clip: %h/%0d required 40/8", out_result, out_flag_count);
        end
        release_out("len15");
    endtask

    task automatic test_back_to_back();
        issue(7'h01, 7'h2C, 24'o111, 4'd3);
        wait_done("bp");
        sb.push_back(mk(7'h2A, 7'h03, 24'o0, 4'd1));
        in_a = 7'h2A; in_b = 7'h03; in_prog = 24'o0; in_len = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 7'h10 ||
                out_flag_count !== 4'd3 || out_zero_seen !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h count=%0d zero=%b required 1 0 10 3 0",
                         i, out_valid, in_ready, out_result, out_flag_count, out_zero_seen);
            end
        end
        release_out("bp");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("bp_next");
        release_out("bp_next");
    endtask

    task automatic test_reset_midrun();
        issue(7'h01, 7'h09, 24'o111, 4'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 7'd0 || alu_op !== 3'd0 || alu_b !== 7'd0) begin
            fails++;
            $display("FAIL midrun_reset: valid=%b ready=%b alu=%h/%h/%0d required 0 1 0/0/0",
                     out_valid, in_ready, alu_a, alu_b, alu_op);
        end
        issue(7'h12, 7'h44, 24'o2, 4'd1);
        wait_done("op2");
        tests++;
        if (out_result !== 7'h00 || out_zero_seen !== 1'b1 || out_flag_count !== 4'd0) begin
            fails++;
            $display("FAIL op2_value: %h/%0d/%b required 00/0/1", out_result, out_flag_count, out_zero_seen);
        end
        release_out("op2");
        issue(7'h5A, 7'h21, 24'o01201, 4'd5);
        wait_done("mixed");
        release_out("mixed");
    endtask

    initial begin
        test_reset();
        test_not_single();
        test_rotate();
        test_zero_flag();
        test_len_edges();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
